// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the 4x24 LDPC decoder iteration scheduler.
// The write-back alignment depth is derived from the memory and VPU latencies.
package ldpc_pkg;

  localparam int N_COL      = 24;
  localparam int COL_AW     = 5;
  localparam int ITER_W     = 6;
  localparam int MEM_RD_LAT = 1;
  localparam int VPU_LAT    = 3;
  localparam int DLY_DEPTH  = MEM_RD_LAT + VPU_LAT;
  localparam int DRAIN_W    = $clog2(DLY_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CN_WAIT  = 3'd1,
    VN_ISSUE = 3'd2,
    VN_DRAIN = 3'd3,
    CHECK    = 3'd4
  } state_t;

  // A programmed cap of zero still runs one full iteration.
  function automatic logic [ITER_W-1:0] eff_cap(input logic [ITER_W-1:0] m);
    return (m == '0) ? ITER_W'(1) : m;
  endfunction

endpackage

// File: rtl/ldpc_dly_line.sv
// Fixed-depth shift register with async clear and sync flush; the MSB of each
// word is treated as a valid bit so an intermediate valid tap can be exposed.
module ldpc_dly_line #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 6,
  parameter int MID_TAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_mid_vld,
  output logic [WIDTH-1:0] o_last
);

  logic [DEPTH-1:0][WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q <= '0;
    end else begin
      r_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign o_mid_vld = r_q[MID_TAP-1][WIDTH-1];
  assign o_last    = r_q[DEPTH-1];

endmodule

// File: rtl/ldpc_vpu_sched.sv
// LDPC iteration scheduler: CN phase handshake, 24-column VN sweep with
// latency-aligned VPU enable and write-back, early exit on syndrome or cap.
module ldpc_vpu_sched
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  output logic              cn_start,
  input  logic              cn_done,
  input  logic              synd_ok,
  output logic              rd_en,
  output logic [COL_AW-1:0] rd_addr,
  output logic              vpu_en,
  output logic              wr_en,
  output logic [COL_AW-1:0] wr_addr,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              done,
  output logic              success
);

  localparam int PW = COL_AW + 1;

  state_t              r_state;
  logic [ITER_W-1:0]   r_cap;
  logic [ITER_W-1:0]   r_iter;
  logic [DRAIN_W-1:0]  r_drain;
  logic                r_cn_start;
  logic                r_rd_en;
  logic [COL_AW-1:0]   r_rd_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_success;

  logic                w_flush;
  logic                w_vpu_en;
  logic [PW-1:0]       w_last;

  // Abort in IDLE is harmless; flushing an already-empty pipeline changes nothing.
  assign w_flush = abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cap      <= '0;
      r_iter     <= '0;
      r_drain    <= '0;
      r_cn_start <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
    end else begin
      r_cn_start <= 1'b0;
      r_done     <= 1'b0;
      if (abort) begin
        if (r_state != IDLE) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_success <= 1'b0;
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
        end
      end else begin
        case (r_state)
          IDLE: begin
            // A start coinciding with the done pulse belongs to the finished decode.
            if (start && !r_done) begin
              r_cap      <= eff_cap(max_iter);
              r_iter     <= '0;
              r_success  <= 1'b0;
              r_busy     <= 1'b1;
              r_cn_start <= 1'b1;
              r_state    <= CN_WAIT;
            end
          end
          CN_WAIT: begin
            if (cn_done) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_state   <= VN_ISSUE;
            end
          end
          VN_ISSUE: begin
            if (r_rd_addr == COL_AW'(N_COL - 1)) begin
              r_rd_en   <= 1'b0;
              r_rd_addr <= '0;
              r_drain   <= DRAIN_W'(DLY_DEPTH - 1);
              r_state   <= VN_DRAIN;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
          end
          VN_DRAIN: begin
            if (r_drain == '0) begin
              if (r_iter != r_cap) begin
                r_iter <= r_iter + 1'b1;
              end
              r_state <= CHECK;
            end else begin
              r_drain <= r_drain - 1'b1;
            end
          end
          CHECK: begin
            if (synd_ok || (r_iter == r_cap)) begin
              r_success <= synd_ok;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_cn_start <= 1'b1;
              r_state    <= CN_WAIT;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  ldpc_dly_line #(
    .DEPTH  (DLY_DEPTH),
    .WIDTH  (PW),
    .MID_TAP(MEM_RD_LAT)
  ) u_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (w_flush),
    .i_d      ({r_rd_en, r_rd_addr}),
    .o_mid_vld(w_vpu_en),
    .o_last   (w_last)
  );

  assign cn_start = r_cn_start;
  assign rd_en    = r_rd_en;
  assign rd_addr  = r_rd_addr;
  assign vpu_en   = w_vpu_en;
  assign wr_en    = w_last[PW-1];
  assign wr_addr  = w_last[COL_AW-1:0];
  assign iter_cnt = r_iter;
  assign busy     = r_busy;
  assign done     = r_done;
  assign success  = r_success;

endmodule

// File: tb/tb_ldpc_vpu_sched.sv
// Self-checking bench for ldpc_vpu_sched: scoreboard of issued reads checked
// against write-backs, plus per-scenario decode outcome checks.
module tb_ldpc_vpu_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] max_iter = '0;
  logic       cn_start;
  logic       cn_done = 1'b0;
  logic       synd_ok = 1'b0;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       vpu_en;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [5:0] iter_cnt;
  logic       busy;
  logic       done;
  logic       success;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_total = 0;
  int exp_col = 0;
  logic prev_rd = 1'b0;

  typedef struct {
    logic [4:0] a;
    int         t;
  } rd_t;
  rd_t sb_q[$];

  typedef struct {
    int         n_cn;
    int         n_wr;
    bit         done_seen;
    bit         aborted;
    logic       succ;
    logic [5:0] it_end;
    logic [5:0] it1;
    logic       busy1;
    logic       busy_after;
    int         lat;
    int         gap;
    logic [4:0] post;
  } res_t;

  ldpc_vpu_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .max_iter(max_iter),
    .cn_start(cn_start),
    .cn_done (cn_done),
    .synd_ok (synd_ok),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .vpu_en  (vpu_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iter_cnt(iter_cnt),
    .busy    (busy),
    .done    (done),
    .success (success)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every read pushes its column; the matching write must arrive 4 cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_col = 0;
      prev_rd = 1'b0;
    end else begin
      n_checks++;
      if (vpu_en !== prev_rd) begin
        n_errors++;
        $display("FAIL vpu_align: vpu_en=%0b expected %0b at cycle %0d", vpu_en, prev_rd, cyc);
      end
      if (rd_en) begin
        n_checks++;
        if (rd_addr !== exp_col[4:0]) begin
          n_errors++;
          $display("FAIL rd_addr_seq: rd_addr=%0d expected %0d at cycle %0d", rd_addr, exp_col, cyc);
        end
        exp_col = (exp_col + 1) % 24;
        sb_q.push_back('{a: rd_addr, t: cyc});
      end
      if (wr_en) begin
        rd_t e;
        wr_total++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL wr_spurious: wr_en=1 addr=%0d with no pending read, expected wr_en=0", wr_addr);
        end else begin
          e = sb_q.pop_front();
          if (wr_addr !== e.a || (cyc - e.t) != 4) begin
            n_errors++;
            $display("FAIL wr_align: wr_addr=%0d lat=%0d expected addr=%0d lat=4", wr_addr, cyc - e.t, e.a);
          end
        end
      end
      prev_rd = rd_en;
      if (abort && busy) begin
        sb_q.delete();
        exp_col = 0;
        prev_rd = 1'b0;
      end
    end
  end

  task automatic run_decode(input logic [5:0] mi, input logic synd, input int dly,
                            input int abort_it, input bit glitch, output res_t r);
    int pend = -1;
    int wr0;
    int t_first = -1;
    int t_last = -1;
    bit ab_pend = 0;
    r = '{default: 0};
    wr0 = wr_total;
    @(posedge clk); #1;
    max_iter = mi;
    synd_ok  = synd;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    r.busy1 = busy;
    r.it1   = iter_cnt;
    for (int c = 0; c < 3000; c++) begin
      if (ab_pend) begin
        r.post    = {rd_en, vpu_en, wr_en, busy, done};
        r.succ    = success;
        r.aborted = 1;
        abort     = 1'b0;
        break;
      end
      cn_done = 1'b0;
      start   = 1'b0;
      if (cn_start) begin
        r.n_cn++;
        if (t_first < 0) t_first = cyc;
        else r.gap = cyc - t_last;
        t_last = cyc;
        pend   = dly;
      end
      if (pend == 0) begin
        cn_done = 1'b1;
        pend    = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (glitch && rd_en && rd_addr == 5'd5) cn_done = 1'b1;
      if (glitch && rd_en && rd_addr == 5'd8) start = 1'b1;
      if (abort_it != 0 && r.n_cn == abort_it && rd_en && rd_addr == 5'd10) begin
        abort   = 1'b1;
        ab_pend = 1;
      end
      if (done) begin
        r.done_seen = 1;
        r.succ      = success;
        r.it_end    = iter_cnt;
        r.lat       = cyc - t_first;
        if (glitch) start = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        r.busy_after = busy;
        break;
      end
      @(posedge clk); #1;
    end
    cn_done = 1'b0;
    r.n_wr  = wr_total - wr0;
  endtask

  task automatic test_reset();
    logic [30:0] outs;
    outs = {cn_start, rd_en, rd_addr, vpu_en, wr_en, wr_addr, iter_cnt, busy, done, success};
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_single_pass();
    res_t r;
    run_decode(6'd5, 1'b1, 10, 0, 0, r);
    n_checks++; if (!r.done_seen) begin n_errors++; $display("FAIL single_done: done_seen=0 expected 1"); end
    n_checks++; if (r.busy1 !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %0b expected 1", r.busy1); end
    n_checks++; if (r.it1 !== 6'd0) begin n_errors++; $display("FAIL single_iter0: got %0d expected 0", r.it1); end
    n_checks++; if (r.succ !== 1'b1) begin n_errors++; $display("FAIL single_success: got %0b expected 1", r.succ); end
    n_checks++; if (r.it_end !== 6'd1) begin n_errors++; $display("FAIL single_iter: got %0d expected 1", r.it_end); end
    n_checks++; if (r.n_cn != 1) begin n_errors++; $display("FAIL single_cn: got %0d expected 1", r.n_cn); end
    n_checks++; if (r.n_wr != 24) begin n_errors++; $display("FAIL single_wr: got %0d expected 24", r.n_wr); end
    n_checks++; if (r.lat != 40) begin n_errors++; $display("FAIL single_lat: got %0d expected 40", r.lat); end
    n_checks++; if (r.busy_after !== 1'b0) begin n_errors++; $display("FAIL single_busy_after: got %0b expected 0", r.busy_after); end
    n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL single_drain: pending=%0d expected 0", sb_q.size()); end
  endtask

  task automatic test_iter_cap();
    res_t r;
    run_decode(6'd3, 1'b0, 4, 0, 0, r);
    n_checks++; if (!r.done_seen) begin n_errors++; $display("FAIL cap_done: done_seen=0 expected 1"); end
    n_checks++; if (r.n_cn != 3) begin n_errors++; $display("FAIL cap_cn: got %0d expected 3", r.n_cn); end
    n_checks++; if (r.n_wr != 72) begin n_errors++; $display("FAIL cap_wr: got %0d expected 72", r.n_wr); end
    n_checks++; if (r.succ !== 1'b0) begin n_errors++; $display("FAIL cap_success: got %0b expected 0", r.succ); end
    n_checks++; if (r.it_end !== 6'd3) begin n_errors++; $display("FAIL cap_iter: got %0d expected 3", r.it_end); end
    n_checks++; if (r.gap != 34) begin n_errors++; $display("FAIL cap_period: got %0d expected 34", r.gap); end
    n_checks++; if (r.lat != 102) begin n_errors++; $display("FAIL cap_lat: got %0d expected 102", r.lat); end
    n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL cap_drain: pending=%0d expected 0", sb_q.size()); end
  endtask

  task automatic test_max_iter_zero();
    res_t r;
    run_decode(6'd0, 1'b0, 2, 0, 0, r);
    n_checks++; if (!r.done_seen) begin n_errors++; $display("FAIL zero_done: done_seen=0 expected 1"); end
    n_checks++; if (r.n_cn != 1) begin n_errors++; $display("FAIL zero_cn: got %0d expected 1", r.n_cn); end
    n_checks++; if (r.it_end !== 6'd1) begin n_errors++; $display("FAIL zero_iter: got %0d expected 1", r.it_end); end
    n_checks++; if (r.n_wr != 24) begin n_errors++; $display("FAIL zero_wr: got %0d expected 24", r.n_wr); end
    n_checks++; if (r.lat != 32) begin n_errors++; $display("FAIL zero_lat: got %0d expected 32", r.lat); end
  endtask

  task automatic test_abort();
    res_t r;
    int   done_seen = 0;
    run_decode(6'd5, 1'b0, 3, 2, 0, r);
    n_checks++; if (!r.aborted) begin n_errors++; $display("FAIL abort_reached: aborted=0 expected 1"); end
    n_checks++; if (r.post !== 5'b0) begin n_errors++; $display("FAIL abort_outputs: {rd,vpu,wr,busy,done}=%b expected 00000", r.post); end
    n_checks++; if (r.succ !== 1'b0) begin n_errors++; $display("FAIL abort_success: got %0b expected 0", r.succ); end
    n_checks++; if (r.n_wr != 31) begin n_errors++; $display("FAIL abort_wr: got %0d expected 31", r.n_wr); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy || wr_en) done_seen++;
    end
    n_checks++; if (done_seen != 0) begin n_errors++; $display("FAIL abort_quiet: active cycles=%0d expected 0", done_seen); end
    run_decode(6'd2, 1'b0, 1, 0, 0, r);
    n_checks++; if (r.it1 !== 6'd0) begin n_errors++; $display("FAIL restart_iter0: got %0d expected 0", r.it1); end
    n_checks++; if (r.n_cn != 2) begin n_errors++; $display("FAIL restart_cn: got %0d expected 2", r.n_cn); end
    n_checks++; if (r.it_end !== 6'd2) begin n_errors++; $display("FAIL restart_iter: got %0d expected 2", r.it_end); end
    n_checks++; if (r.n_wr != 48) begin n_errors++; $display("FAIL restart_wr: got %0d expected 48", r.n_wr); end
  endtask

  task automatic test_handshake();
    res_t r;
    run_decode(6'd2, 1'b0, 5, 0, 1, r);
    n_checks++; if (!r.done_seen) begin n_errors++; $display("FAIL hs_done: done_seen=0 expected 1"); end
    n_checks++; if (r.n_cn != 2) begin n_errors++; $display("FAIL hs_cn: got %0d expected 2", r.n_cn); end
    n_checks++; if (r.n_wr != 48) begin n_errors++; $display("FAIL hs_wr: got %0d expected 48", r.n_wr); end
    n_checks++; if (r.it_end !== 6'd2) begin n_errors++; $display("FAIL hs_iter: got %0d expected 2", r.it_end); end
    n_checks++; if (r.gap != 35) begin n_errors++; $display("FAIL hs_period: got %0d expected 35", r.gap); end
    n_checks++; if (r.busy_after !== 1'b0) begin n_errors++; $display("FAIL hs_start_on_done: busy=%0b expected 0", r.busy_after); end
  endtask

  task automatic test_reset_mid();
    res_t        r;
    logic [30:0] outs;
    logic        was_rd = 1'b0;
    bit          hit = 0;
    @(posedge clk); #1;
    max_iter = 6'd5;
    synd_ok  = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      cn_done = cn_start;
      if (was_rd && !rd_en) begin
        hit = 1;
        #2;
        rst_n = 1'b0;
        #1;
        outs = {cn_start, rd_en, rd_addr, vpu_en, wr_en, wr_addr, iter_cnt, busy, done, success};
        break;
      end
      was_rd = rd_en;
      @(posedge clk); #1;
    end
    cn_done = 1'b0;
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL rstmid_timeout: drain not reached, expected within 200 cycles");
    end else if (outs !== '0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_decode(6'd1, 1'b1, 0, 0, 0, r);
    n_checks++; if (r.n_cn != 1) begin n_errors++; $display("FAIL rstmid_cn: got %0d expected 1", r.n_cn); end
    n_checks++; if (r.it_end !== 6'd1) begin n_errors++; $display("FAIL rstmid_iter: got %0d expected 1", r.it_end); end
    n_checks++; if (r.succ !== 1'b1) begin n_errors++; $display("FAIL rstmid_success: got %0b expected 1", r.succ); end
    n_checks++; if (r.n_wr != 24) begin n_errors++; $display("FAIL rstmid_wr: got %0d expected 24", r.n_wr); end
    n_checks++; if (r.lat != 30) begin n_errors++; $display("FAIL rstmid_lat: got %0d expected 30", r.lat); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    test_single_pass();
    test_iter_cap();
    test_max_iter_zero();
    test_abort();
    test_handshake();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
